// File: rtl/adc_pkg.sv
// Shared widths, scan FSM state encoding and result record for the ADC scan scheduler.
package adc_pkg;

    localparam int ADC_W = 12;
    localparam int CH_W  = 3;
    localparam int ACC_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT_DONE,
        STORE,
        NEXT
    } scan_state_t;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [ADC_W-1:0] data;
    } adc_result_t;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [7:0] mask);
        logic found;
        lowest_ch = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i] && !found) begin
                lowest_ch = CH_W'(i);
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/adc_scan_timer.sv
// Free-running scan period timer: one-cycle tick every max(period,2) cycles while enabled.
module adc_scan_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] cnt;
    logic [15:0] last;

    // >= rather than == so a period shortened below the current count wraps at once
    always_comb begin
        last = (period < 16'd2) ? 16'd1 : period - 16'd1;
        tick = enable && (cnt >= last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel ADC scan sequencer with sticky overrun and conversion-timeout flags.
// Define ADC_SCAN_AVG_EN to convert each channel four times and report the truncated average.
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [15:0]      period,
    input  logic [7:0]       ch_mask,
    input  logic             ovr_clr,
    output logic             conv_req,
    output logic [CH_W-1:0]  conv_ch,
    input  logic             conv_done,
    input  logic [ADC_W-1:0] conv_data,
    output logic             res_valid,
    output logic [CH_W-1:0]  res_ch,
    output logic [ADC_W-1:0] res_data,
    output logic             scan_done,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam logic [7:0]  CH_VALID = 8'((1 << NUM_CH) - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    scan_state_t      state, state_nxt;
    logic             tick;
    logic [7:0]       scan_mask, start_mask, remaining;
    logic [CH_W-1:0]  cur_ch;
    logic [31:0]      tcnt;
    logic             waiting, tmo_hit, last_conv;
    logic [ADC_W-1:0] done_data;
    adc_result_t      result;

    adc_scan_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .period  (period),
        .tick    (tick)
    );

    always_comb begin
        start_mask = ch_mask & CH_VALID;
        remaining  = scan_mask & ~(8'b1 << cur_ch);
        waiting    = (state == REQ) || (state == WAIT_DONE);
        tmo_hit    = waiting && !conv_done && (tcnt == TMO_LAST);
    end

`ifdef ADC_SCAN_AVG_EN
    logic [ACC_W-1:0] acc, acc_sum;
    logic [1:0]       avg_cnt;

    always_comb begin
        acc_sum   = acc + ACC_W'(conv_data);
        last_conv = (avg_cnt == 2'd3);
        done_data = acc_sum[ACC_W-1:2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (state == NEXT || (waiting && conv_done && last_conv)) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (waiting && conv_done) begin
            acc     <= acc_sum;
            avg_cnt <= avg_cnt + 2'd1;
        end
    end
`else
    always_comb begin
        last_conv = 1'b1;
        done_data = conv_data;
    end
`endif

    always_comb begin
        state_nxt = state;
        conv_req  = waiting;
        busy      = (state != IDLE);
        res_valid = (state == STORE);
        scan_done = 1'b0;
        case (state)
            IDLE:      if (tick && start_mask != '0) state_nxt = SELECT;
            SELECT:    state_nxt = REQ;
            // Intermediate averaging samples re-enter SELECT so conv_req drops for a cycle
            REQ, WAIT_DONE: begin
                if (conv_done)    state_nxt = last_conv ? STORE : SELECT;
                else if (tmo_hit) state_nxt = NEXT;
                else              state_nxt = WAIT_DONE;
            end
            STORE:     state_nxt = NEXT;
            NEXT: begin
                if (enable && remaining != '0) begin
                    state_nxt = SELECT;
                end else begin
                    state_nxt = IDLE;
                    scan_done = enable;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            scan_mask   <= '0;
            cur_ch      <= '0;
            tcnt        <= '0;
            result      <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:   if (tick && start_mask != '0) scan_mask <= start_mask;
                SELECT: begin
                    cur_ch <= lowest_ch(scan_mask);
                    tcnt   <= '0;
                end
                REQ, WAIT_DONE: begin
                    if (conv_done) begin
                        if (last_conv) result <= '{ch: cur_ch, data: done_data};
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                NEXT:   scan_mask <= remaining;
                default: ;
            endcase
            if (tick && busy) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (ovr_clr) timeout_err <= 1'b0;
        end
    end

    assign conv_ch  = cur_ch;
    assign res_ch   = result.ch;
    assign res_data = result.data;

endmodule
